// File: rtl/phase_scheduler.sv
// rtl/phase_scheduler.sv - four-phase intersection scheduler with clearance sequencing and preemption
module phase_scheduler #(
  parameter int TW        = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_id,
  output logic [1:0] phase,
  output logic [3:0] grant,
  output logic       yellow,
  output logic       all_red,
  output logic [3:0] pend,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [1:0]    phase_d, nxt, nxt_d, rr_pick;
  logic [TW-1:0] elapsed, elapsed_d, cnt, cnt_d;
  logic [3:0]    pend_d, set_mask, clr_mask, other_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_GREEN;
      phase   <= 2'd0;
      elapsed <= '0;
      cnt     <= '0;
      nxt     <= 2'd0;
      pend    <= 4'd0;
    end else begin
      state   <= state_d;
      phase   <= phase_d;
      elapsed <= elapsed_d;
      cnt     <= cnt_d;
      nxt     <= nxt_d;
      pend    <= pend_d;
    end
  end

  always_comb begin
    state_d    = state;
    phase_d    = phase;
    elapsed_d  = elapsed;
    cnt_d      = cnt;
    nxt_d      = nxt;
    clr_mask   = 4'd0;
    set_mask   = req;
    other_mask = pend;
    other_mask[phase] = 1'b0;
    if (state == S_GREEN) set_mask[phase] = 1'b0;
    // descending scan so the nearest phase after the current one wins
    rr_pick = phase;
    for (int k = 3; k >= 1; k--) begin
      if (other_mask[phase + 2'(k)]) rr_pick = phase + 2'(k);
    end
    case (state)
      S_GREEN: begin
        if (preempt && (preempt_id != phase)) begin
          state_d = S_YELLOW;
          nxt_d   = preempt_id;
          cnt_d   = TW'(YELLOW_T);
        end else if (!preempt && (|other_mask) && (elapsed >= TW'(GREEN_MIN)) &&
                     (!req[phase] || (elapsed >= TW'(GREEN_MAX)))) begin
          state_d = S_YELLOW;
          nxt_d   = rr_pick;
          cnt_d   = TW'(YELLOW_T);
        end else if (tick && (elapsed < TW'(GREEN_MAX))) begin
          elapsed_d = elapsed + TW'(1);
        end
      end
      S_YELLOW, S_ALLRED: begin
        if (preempt) nxt_d = preempt_id;
        if (tick) begin
          if (cnt == TW'(1)) begin
            if (state == S_YELLOW) begin
              state_d = S_ALLRED;
              cnt_d   = TW'(ALLRED_T);
            end else begin
              state_d   = S_GREEN;
              phase_d   = nxt_d;
              elapsed_d = '0;
              cnt_d     = '0;
              clr_mask[nxt_d] = 1'b1;
            end
          end else begin
            cnt_d = cnt - TW'(1);
          end
        end
      end
      default: state_d = S_GREEN;
    endcase
    // clear of the newly served phase overrides a same-cycle request
    pend_d = (pend | set_mask) & ~clr_mask;
  end

  always_comb begin
    grant   = (state == S_GREEN) ? (4'b0001 << phase) : 4'b0000;
    yellow  = (state == S_YELLOW);
    all_red = (state == S_ALLRED);
    busy    = (state == S_YELLOW) || (state == S_ALLRED);
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// tb/tb_phase_scheduler.sv - randomized and directed checks of phase_scheduler against a reference model
module tb_phase_scheduler;

  localparam int GMIN = 4, GMAX = 10, YT = 2, ART = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic [3:0] req = 4'd0;
  logic       preempt = 1'b0;
  logic [1:0] preempt_id = 2'd0;
  logic [1:0] phase;
  logic [3:0] grant, pend;
  logic       yellow, all_red, busy;

  int checks = 0;
  int failures = 0;

  // reference model: mode 0 green, 1 yellow, 2 all-red
  int       m_mode, m_phase, m_el, m_cnt, m_nxt;
  bit [3:0] m_pend;

  phase_scheduler #(.TW(4), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALLRED_T(ART)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .preempt(preempt),
    .preempt_id(preempt_id), .phase(phase), .grant(grant), .yellow(yellow),
    .all_red(all_red), .pend(pend), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_el = 0; m_cnt = 0; m_nxt = 0; m_pend = 4'd0;
  endtask

  task automatic model_step();
    bit [3:0] np;
    bit       other, leave;
    int       target;
    np = m_pend;
    for (int i = 0; i < 4; i++)
      if (req[i] && !(m_mode == 0 && i == m_phase)) np[i] = 1'b1;
    if (m_mode == 0) begin
      other = 1'b0;
      for (int i = 0; i < 4; i++) if (i != m_phase && m_pend[i]) other = 1'b1;
      leave = 1'b0;
      target = m_phase;
      if (preempt && int'(preempt_id) != m_phase) begin
        leave = 1'b1;
        target = int'(preempt_id);
      end else if (!preempt && other && m_el >= GMIN && (!req[m_phase] || m_el >= GMAX)) begin
        leave = 1'b1;
        for (int k = 3; k >= 1; k--) if (m_pend[(m_phase + k) % 4]) target = (m_phase + k) % 4;
      end
      if (leave) begin
        m_mode = 1; m_cnt = YT; m_nxt = target;
      end else if (tick && m_el < GMAX) begin
        m_el++;
      end
    end else begin
      if (preempt) m_nxt = int'(preempt_id);
      if (tick) begin
        if (m_cnt == 1) begin
          if (m_mode == 1) begin
            m_mode = 2; m_cnt = ART;
          end else begin
            m_mode = 0; m_phase = m_nxt; m_el = 0; m_cnt = 0;
            np[m_nxt] = 1'b0;
          end
        end else begin
          m_cnt--;
        end
      end
    end
    m_pend = np;
  endtask

  task automatic cmp_all();
    check("phase", 32'(phase), 32'(m_phase));
    check("grant", 32'(grant), (m_mode == 0) ? (32'd1 << m_phase) : 32'd0);
    check("yellow", 32'(yellow), 32'(m_mode == 1));
    check("all_red", 32'(all_red), 32'(m_mode == 2));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("pend", 32'(pend), 32'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    req = 4'd0; preempt = 1'b0; preempt_id = 2'd0; tick = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int g0, yc, ac, first_y, seen;
    int seq[$];
    logic [3:0] prev_grant;

    do_reset();
    check("rst_grant", 32'(grant), 32'h1);
    check("rst_pend", 32'(pend), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // idle rest on phase 0
    for (int s = 0; s < 50; s++) step();
    check("idle_grant", 32'(grant), 32'h1);
    check("idle_busy", 32'(busy), 32'h0);

    // single request pulse for phase 2
    do_reset();
    g0 = 0; yc = 0; ac = 0;
    for (int s = 1; s <= 20; s++) begin
      req = (s == 1) ? 4'b0100 : 4'b0000;
      step();
      if (grant == 4'b0001) g0++;
      if (yellow) begin
        yc++;
        check("y_phase", 32'(phase), 32'd0);
      end
      if (all_red) ac++;
    end
    check("p2_green0", 32'(g0), 32'd4);
    check("p2_yellow", 32'(yc), 32'd2);
    check("p2_allred", 32'(ac), 32'd1);
    check("p2_grant", 32'(grant), 32'b0100);
    check("p2_phase", 32'(phase), 32'd2);
    check("p2_pend", 32'(pend), 32'd0);

    // extension to max green, then early drop of own demand
    for (int pass = 0; pass < 2; pass++) begin
      int drop;
      drop = (pass == 0) ? 100 : 6;
      do_reset();
      g0 = 0; first_y = 0;
      for (int s = 1; s <= 20; s++) begin
        req = (s <= drop) ? 4'b0011 : 4'b0010;
        step();
        if (grant == 4'b0001) g0++;
        if (yellow && first_y == 0) first_y = s;
      end
      check(pass == 0 ? "ext_max" : "ext_drop", 32'(g0), pass == 0 ? 32'd10 : 32'd6);
      check("ext_yellow_at", 32'(first_y), pass == 0 ? 32'd11 : 32'd7);
    end

    // round-robin service 1,2,3 then rest on 3
    do_reset();
    yc = 0; ac = 0;
    prev_grant = grant;
    for (int s = 1; s <= 60; s++) begin
      req = (s == 1) ? 4'b1110 : 4'b0000;
      step();
      if (grant != 4'd0 && prev_grant == 4'd0) seq.push_back(int'(phase));
      if (yellow) yc++;
      if (all_red) ac++;
      prev_grant = grant;
    end
    check("rr_count", 32'(seq.size()), 32'd3);
    for (int i = 0; i < seq.size() && i < 3; i++) check("rr_order", 32'(seq[i]), 32'(i + 1));
    check("rr_yellow", 32'(yc), 32'd6);
    check("rr_allred", 32'(ac), 32'd3);
    check("rr_rest", 32'(grant), 32'b1000);

    // preemption to phase 3, hold, then resume
    do_reset();
    preempt = 1'b1; preempt_id = 2'd3;
    step();
    check("pre_yellow", 32'(yellow), 32'd1);
    for (int s = 0; s < 5; s++) step();
    check("pre_grant", 32'(grant), 32'b1000);
    req = 4'b0010;
    step();
    req = 4'b0000;
    for (int s = 0; s < 8; s++) step();
    check("pre_hold", 32'(grant), 32'b1000);
    check("pre_pend", 32'(pend), 32'b0010);
    preempt = 1'b0;
    seen = 0;
    for (int s = 0; s < 12 && seen == 0; s++) begin
      step();
      if (grant == 4'b0010) seen = 1;
    end
    check("pre_resume", 32'(seen), 32'd1);

    // reset in the middle of yellow
    do_reset();
    preempt = 1'b1; preempt_id = 2'd1;
    step();
    preempt = 1'b0; req = 4'b0100;
    step();
    req = 4'b0000;
    check("mid_y_pre", 32'(yellow), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_y_grant", 32'(grant), 32'b0001);
    check("mid_y_yellow", 32'(yellow), 32'd0);
    check("mid_y_pend", 32'(pend), 32'd0);
    step();
    rst_n = 1'b1;

    // tick held low during all-red freezes the sequence
    do_reset();
    preempt = 1'b1; preempt_id = 2'd2;
    step();
    preempt = 1'b0;
    step();
    step();
    check("frz_allred", 32'(all_red), 32'd1);
    tick = 1'b0;
    for (int s = 0; s < 20; s++) begin
      req = 4'($urandom_range(0, 15));
      step();
    end
    check("frz_held", 32'(all_red), 32'd1);
    tick = 1'b1; req = 4'd0;
    step();
    check("frz_release", 32'(grant), 32'b0100);

    // randomized traffic against the model
    do_reset();
    for (int s = 0; s < 4000; s++) begin
      int dens;
      dens = (s / 500) % 4;
      tick = ($urandom_range(0, 3) != 0) || (dens == 0);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9 + 4 * dens) == 0) req[i] = ~req[i];
      if (preempt) begin
        if ($urandom_range(0, 19) == 0) preempt = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        preempt = 1'b1;
        preempt_id = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_all();
      end
      step();
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
- Intersection phase scheduler that shares the green right-of-way among four approach requesters (phases 0-3).
- Sequences each handover through GREEN -> YELLOW -> ALL_RED, with minimum green, extension up to maximum green, and fixed clearance times.
- Timing is measured in ticks of an external timebase enable.
- Phase 0 is the main road; the block rests on the current green when nobody else is waiting, and supports emergency preemption.

Parameters:
- TW, 4: width of all timers in bits.
- GREEN_MIN, 4: minimum green in ticks; must be >= 1.
- GREEN_MAX, 10: maximum green in ticks while own demand persists; must be >= GREEN_MIN and < 2^TW.
- YELLOW_T, 2: yellow duration in ticks; must be >= 1.
- ALLRED_T, 1: all-red clearance in ticks; must be >= 1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- tick, input, 1: timebase enable; timers advance only on cycles where tick=1.
- req, input, 4: per-phase demand (sensor level), one bit per phase.
- preempt, input, 1: emergency preemption request, level sensitive.
- preempt_id, input, 2: phase to be served during preemption.
- phase, output, 2: current phase index.
- grant, output, 4: one-hot green for phase; all zero outside GREEN.
- yellow, output, 1: high while phase is showing yellow.
- all_red, output, 1: high during ALL_RED.
- pend, output, 4: latched pending requests.
- busy, output, 1: high in YELLOW or ALL_RED.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=GREEN, phase=0, grant=4'b0001, yellow=0, all_red=0, busy=0.
  - pend=0, elapsed=0, clearance counter=0, nxt=0.
- All outputs are registered and decoded from the state registers. They change on the edge where the state changes: a condition seen in cycle N is visible in cycle N+1.
- Pending latch:
  - pend[i] is set on any cycle with req[i]=1, except i==phase while in GREEN (that phase is already served).
  - pend[nxt] is cleared on the edge entering GREEN for nxt. Clear has priority over set on that edge.
- GREEN state:
  - elapsed increments on each tick and saturates at GREEN_MAX.
  - other = |(pend with bit phase masked).
  - Leave GREEN when other=1 AND elapsed >= GREEN_MIN AND (req[phase]=0 OR elapsed >= GREEN_MAX).
  - If other=0, stay green indefinitely (rest).
  - On leaving, nxt = first set pend bit searching phase+1, phase+2, phase+3 modulo 4 (round-robin).
  - Go to YELLOW and load the clearance counter with YELLOW_T.
- YELLOW state:
  - Counter decrements on each tick.
  - On a cycle with tick=1 and counter==1, go to ALL_RED and load ALLRED_T.
  - YELLOW therefore spans exactly YELLOW_T ticks.
- ALL_RED state:
  - Same counting rule as YELLOW.
  - On expiry: enter GREEN, phase=nxt, elapsed=0, clear pend[nxt].
- Preemption:
  - preempt=1 in GREEN with phase != preempt_id: leave immediately, ignoring GREEN_MIN. Set nxt=preempt_id and go to YELLOW.
  - preempt=1 in GREEN with phase == preempt_id: hold GREEN; no exit while preempt stays high.
  - preempt=1 in YELLOW or ALL_RED: overwrite nxt with preempt_id. Clearance timing is never shortened.
  - When preempt drops, normal arbitration resumes from the current phase.
- Simultaneous events:
  - Several pend bits set: round-robin order decides.
  - A req for a phase arriving during its own YELLOW or ALL_RED sets pend normally; that phase is re-served later.
- Reset mid-operation (any state): immediate return to the reset values; no yellow is shown.
- tick=0 freezes all timers; request latching continues.

Test Plan:
- Reset, then tick=1 every cycle, no req -> grant=0001 held for 50 cycles, pend=0, busy=0.
- req[2] pulsed 1 cycle at cycle 1 ->
  - grant=0001 for 4 cycles;
  - yellow=1 with phase=0 for 2 cycles;
  - all_red=1 for 1 cycle;
  - then grant=0100, phase=2, pend=0.
- req[0] held high and req[1] set -> green 0 extends to 10 ticks, then yellow. Repeat with req[0] dropping at tick 6 -> exit at tick 6.
- pend=1110 while in phase 0 -> served in order 1, 2, 3, then rest on 3. Check each green begins only after 2 yellow + 1 all-red ticks.
- preempt=1, preempt_id=3 at tick 1 of green 0 ->
  - immediate yellow (min green skipped), then all-red, then grant=1000;
  - green holds while preempt=1, even with pend[1]=1;
  - after preempt drops -> green 3 exits to phase 1.
- Assert rst_n=0 mid-YELLOW -> next cycle grant=0001, yellow=0, pend=0. Also check tick=0 for 20 cycles during ALL_RED -> state frozen.
